// File: rtl/mole_pkg.sv
// Shared types and defaults for the whack-a-mole round engine.
// MOLE_STREAK_BONUS_EN enables the streak-based score bonus.
package mole_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ARMED,
    S_SETTLE,
    S_OVER
  } state_t;

  localparam int unsigned DEF_N_TGT   = 8;
  localparam int unsigned DEF_SCORE_W = 8;
  localparam int unsigned DEF_LIVES   = 3;

  localparam logic [15:0] DEF_ROUND_BASE = 16'd5000;
  localparam logic [15:0] DEF_ROUND_STEP = 16'd1000;
  localparam logic [15:0] DEF_ROUND_MIN  = 16'd1000;
  localparam logic [15:0] DEF_LEVEL_HITS = 16'd5;

  localparam logic [2:0] BONUS_STREAK = 3'd3;

  // max(base - lvl*step, rmin) without wrapping below zero
  function automatic logic [15:0] round_preset(
    input logic [15:0] base,
    input logic [15:0] step,
    input logic [15:0] rmin,
    input logic [3:0]  lvl
  );
    logic [19:0] dec;
    logic [15:0] rem;
    dec = 20'(step) * 20'(lvl);
    rem = (dec >= 20'(base)) ? 16'd0
                             : 16'(20'(base) - dec);
    return (rem < rmin) ? rmin : rem;
  endfunction

endpackage

// File: rtl/mole_round_timer.sv
// Round countdown: loads a preset, decrements on tick,
// holds at zero and flags expiry on a tick at zero.
module mole_round_timer #(
  parameter logic [15:0] RESET_VAL = 16'd5000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] preset,
  input  logic        tick,
  output logic [15:0] count,
  output logic        expired
);

  logic [15:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= RESET_VAL;
    end else if (load) begin
      r_count <= preset;
    end else if (tick && r_count != 16'd0) begin
      r_count <= r_count - 16'd1;
    end
  end

  assign count   = r_count;
  assign expired = tick && (r_count == 16'd0);

endmodule

// File: rtl/mole_round_engine.sv
// Whack-a-mole round engine: loads targets, scores hits, counts misses.
// Define MOLE_STREAK_BONUS_EN for the +2 streak bonus.
module mole_round_engine
  import mole_pkg::*;
#(
  parameter int unsigned N_TGT      = DEF_N_TGT,
  parameter int unsigned SCORE_W    = DEF_SCORE_W,
  parameter int unsigned LIVES      = DEF_LIVES,
  parameter logic [15:0] ROUND_BASE = DEF_ROUND_BASE,
  parameter logic [15:0] ROUND_STEP = DEF_ROUND_STEP,
  parameter logic [15:0] ROUND_MIN  = DEF_ROUND_MIN,
  parameter logic [15:0] LEVEL_HITS = DEF_LEVEL_HITS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               tick,
  input  logic [N_TGT-1:0]   btn,
  input  logic [N_TGT-1:0]   pattern_in,
  output logic               pattern_req,
  output logic [N_TGT-1:0]   targets,
  output logic [N_TGT-1:0]   lockout,
  output logic [SCORE_W-1:0] score,
  output logic [2:0]         lives_left,
  output logic [3:0]         level,
  output logic               hit_pulse,
  output logic               miss_pulse,
  output logic               game_over
);

  state_t             r_state, w_next;
  logic [N_TGT-1:0]   r_targets, r_lockout;
  logic [SCORE_W-1:0] r_score;
  logic [2:0]         r_lives;
  logic [3:0]         r_level;
  logic [15:0]        r_lvl_hits;
  logic               r_hit, r_miss;

  logic               w_load, w_armed, w_restart;
  logic               w_hit, w_expiry, w_miss;
  logic [N_TGT-1:0]   w_live, w_tgt_load;
  logic [15:0]        w_preset, w_unused_count;
  logic               w_lvl_wrap;
  logic [1:0]         w_inc;
  logic [SCORE_W:0]   w_sum;
  logic [SCORE_W-1:0] w_score_nx;

  assign w_load    = (r_state == S_LOAD);
  assign w_armed   = (r_state == S_ARMED);
  assign w_restart = (r_state == S_OVER) && start;

  // locked buttons never count toward a hit
  assign w_live = btn & ~r_lockout;
  assign w_hit  = w_armed && ((r_targets & ~w_live) == '0);
  assign w_miss = w_expiry && !w_hit;

  assign w_tgt_load = (pattern_in == '0)
                    ? {{(N_TGT-1){1'b0}}, 1'b1}
                    : pattern_in;

  assign w_preset = round_preset(ROUND_BASE, ROUND_STEP,
                                 ROUND_MIN, r_level);

  mole_round_timer #(
    .RESET_VAL(ROUND_BASE)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (w_load),
    .preset (w_preset),
    .tick   (tick && w_armed),
    .count  (w_unused_count),
    .expired(w_expiry)
  );

`ifdef MOLE_STREAK_BONUS_EN
  logic [2:0] r_streak;

  always_ff @(posedge clk) begin
    if (rst || w_restart || w_miss) begin
      r_streak <= 3'd0;
    end else if (w_hit && r_streak != 3'd7) begin
      r_streak <= r_streak + 3'd1;
    end
  end

  assign w_inc = (r_streak >= BONUS_STREAK) ? 2'd2 : 2'd1;
`else
  assign w_inc = 2'd1;
`endif

  assign w_sum = {1'b0, r_score}
               + {{(SCORE_W-1){1'b0}}, w_inc};
  assign w_score_nx = w_sum[SCORE_W] ? '1
                                     : w_sum[SCORE_W-1:0];
  assign w_lvl_wrap = (r_lvl_hits == LEVEL_HITS - 16'd1);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (start) w_next = S_LOAD;
      S_LOAD:   w_next = S_ARMED;
      S_ARMED: begin
        if (w_hit) begin
          w_next = S_SETTLE;
        end else if (w_expiry) begin
          w_next = (r_lives == 3'd1) ? S_OVER : S_SETTLE;
        end
      end
      S_SETTLE: if (btn == '0) w_next = S_LOAD;
      S_OVER:   if (start) w_next = S_LOAD;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_targets  <= '0;
      r_lockout  <= '0;
      r_score    <= '0;
      r_level    <= 4'd0;
      r_lvl_hits <= 16'd0;
      r_lives    <= 3'(LIVES);
      r_hit      <= 1'b0;
      r_miss     <= 1'b0;
    end else begin
      r_state <= w_next;
      r_hit   <= w_hit;
      r_miss  <= w_miss;
      if (w_load) begin
        r_targets <= w_tgt_load;
        r_lockout <= '0;
      end else if (w_armed) begin
        r_lockout <= r_lockout | (btn & ~r_targets);
        if (w_hit || w_expiry) r_targets <= '0;
      end
      if (w_hit) begin
        r_score <= w_score_nx;
        if (w_lvl_wrap) begin
          r_lvl_hits <= 16'd0;
          if (r_level != 4'hF) r_level <= r_level + 4'd1;
        end else begin
          r_lvl_hits <= r_lvl_hits + 16'd1;
        end
      end
      if (w_miss) r_lives <= r_lives - 3'd1;
      if (w_restart) begin
        r_score    <= '0;
        r_level    <= 4'd0;
        r_lvl_hits <= 16'd0;
        r_lives    <= 3'(LIVES);
      end
    end
  end

  assign pattern_req = w_load;
  assign targets     = r_targets;
  assign lockout     = r_lockout;
  assign score       = r_score;
  assign lives_left  = r_lives;
  assign level       = r_level;
  assign hit_pulse   = r_hit;
  assign miss_pulse  = r_miss;
  assign game_over   = (r_state == S_OVER);

endmodule

// File: tb/tb_mole_round_engine.sv
// Self-checking bench for mole_round_engine (default parameters).
// Game-level reference model; table, hand-written and random rounds.
module tb_mole_round_engine;

  logic       clk = 1'b0;
  logic       rst, start, tick;
  logic [7:0] btn, pattern_in;
  logic       pattern_req, hit_pulse, miss_pulse, game_over;
  logic [7:0] targets, lockout, score;
  logic [2:0] lives_left;
  logic [3:0] level;

  always #5 clk = ~clk;

  mole_round_engine dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .tick       (tick),
    .btn        (btn),
    .pattern_in (pattern_in),
    .pattern_req(pattern_req),
    .targets    (targets),
    .lockout    (lockout),
    .score      (score),
    .lives_left (lives_left),
    .level      (level),
    .hit_pulse  (hit_pulse),
    .miss_pulse (miss_pulse),
    .game_over  (game_over)
  );

  int checks = 0, failures = 0;
  int n_hit = 0, n_miss = 0;
  int tot_hits = 0, tot_miss = 0;

  always @(negedge clk) begin
    if (hit_pulse) n_hit++;
    if (miss_pulse) n_miss++;
  end

  // reference game state
  int m_score, m_hits, m_lives, m_streak;

  function automatic int m_level();
    int l;
    l = m_hits / 5;
    return (l > 15) ? 15 : l;
  endfunction

  function automatic int preset_of(input int lv);
    int p;
    p = 5000 - lv * 1000;
    return (p < 1000) ? 1000 : p;
  endfunction

  task automatic m_new_game();
    m_score = 0; m_hits = 0; m_lives = 3; m_streak = 0;
  endtask

  task automatic m_do_hit();
    int inc;
    inc = 1;
`ifdef MOLE_STREAK_BONUS_EN
    if (m_streak >= 3) inc = 2;
    if (m_streak < 7) m_streak++;
`endif
    m_score = (m_score + inc > 255) ? 255 : m_score + inc;
    m_hits++;
    tot_hits++;
  endtask

  task automatic m_do_miss();
    m_lives--;
    m_streak = 0;
    tot_miss++;
  endtask

  task automatic check(input string name, input int act,
                       input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req();
    for (int i = 0; i < 20; i++) begin
      if (pattern_req) break;
      step();
    end
    check("pattern_req_wait", pattern_req, 1);
  endtask

  task automatic play_hit(input logic [7:0] pat,
                          input logic [7:0] wrong,
                          input logic [7:0] exp_t,
                          input logic [7:0] exp_l,
                          input bit rtick);
    int k;
    pattern_in = pat;
    btn = 8'h00;
    wait_req();
    step();
    check("pattern_req_one_cycle", pattern_req, 0);
    check("targets_loaded", targets, exp_t);
    if (wrong != 8'h00) begin
      btn = wrong;
      tick = rtick ? 1'($urandom % 2) : 1'b0;
      step();
      check("no_hit_on_wrong", hit_pulse, 0);
      check("lockout_wrong", lockout, exp_l);
    end
    btn = exp_t | wrong;
    tick = rtick ? 1'($urandom % 2) : 1'b0;
    k = 0;
    do begin
      step();
      k++;
    end while (!hit_pulse && k < 5);
    m_do_hit();
    check("hit_latency", k, 1);
    check("hit_pulse", hit_pulse, 1);
    check("no_miss_on_hit", miss_pulse, 0);
    check("score", score, m_score);
    check("level", level, m_level());
    check("lockout_after_hit", lockout, exp_l);
    check("targets_cleared", targets, 0);
    btn = 8'h00;
    tick = 1'b0;
  endtask

  task automatic play_miss(input logic [7:0] pat, input bit full);
    int p, k;
    pattern_in = pat;
    btn = 8'h00;
    wait_req();
    p = preset_of(m_level());
    k = 0;
    tick = full ? 1'b1 : 1'($urandom % 2);
    while (k < 4 * p + 100) begin
      step();
      k++;
      if (miss_pulse || hit_pulse) break;
      tick = full ? 1'b1 : 1'($urandom % 2);
    end
    m_do_miss();
    if (full) check("miss_latency", k, p + 2);
    check("miss_pulse", miss_pulse, 1);
    check("no_hit_on_miss", hit_pulse, 0);
    check("lives", lives_left, m_lives);
    check("game_over", game_over, (m_lives == 0) ? 1 : 0);
    check("targets_after_miss", targets, 0);
    check("score_after_miss", score, m_score);
    tick = 1'b0;
  endtask

  task automatic play_expiry_hit();
    int p;
    logic [7:0] exp_t;
    pattern_in = 8'($urandom);
    exp_t = (pattern_in == 8'h00) ? 8'h01 : pattern_in;
    btn = 8'h00;
    wait_req();
    p = preset_of(m_level());
    tick = 1'b1;
    for (int i = 0; i < p + 1; i++) step();
    check("armed_at_expiry", targets, exp_t);
    btn = exp_t;
    step();
    m_do_hit();
    check("tie_hit_pulse", hit_pulse, 1);
    check("tie_no_miss", miss_pulse, 0);
    check("tie_lives", lives_left, m_lives);
    check("tie_score", score, m_score);
    step();
    check("tie_no_late_miss", miss_pulse, 0);
    btn = 8'h00;
    tick = 1'b0;
  endtask

  typedef struct {
    logic [7:0] pat;
    logic [7:0] wrong;
    logic [7:0] exp_t;
    logic [7:0] exp_l;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [7:0] pat, wr, et;
    vecs[0] = '{8'h05, 8'h00, 8'h05, 8'h00};
    vecs[1] = '{8'h05, 8'h02, 8'h05, 8'h02};
    vecs[2] = '{8'h00, 8'h00, 8'h01, 8'h00};
    vecs[3] = '{8'h80, 8'h7F, 8'h80, 8'h7F};
    vecs[4] = '{8'hFF, 8'h00, 8'hFF, 8'h00};
    vecs[5] = '{8'h0A, 8'hF0, 8'h0A, 8'hF0};

    rst = 1'b1; start = 1'b1; tick = 1'b1;
    btn = 8'h00; pattern_in = 8'h00;
    step(); step(); step();
    check("rst_pattern_req", pattern_req, 0);
    check("rst_targets", targets, 0);
    check("rst_lockout", lockout, 0);
    check("rst_score", score, 0);
    check("rst_level", level, 0);
    check("rst_lives", lives_left, 3);
    check("rst_pulses", {hit_pulse, miss_pulse}, 0);
    check("rst_game_over", game_over, 0);

    rst = 1'b0; start = 1'b0; tick = 1'b0;
    step();
    check("idle_no_load", pattern_req, 0);
    check("idle_targets", targets, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    m_new_game();
    check("start_load", pattern_req, 1);

    foreach (vecs[i])
      play_hit(vecs[i].pat, vecs[i].wrong,
               vecs[i].exp_t, vecs[i].exp_l, 1'b1);

    // held button stalls in settle; start ignored while armed
    pattern_in = 8'h00;
    wait_req();
    step();
    check("zero_pattern_targets", targets, 8'h01);
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_ignored_armed", pattern_req, 0);
    check("start_ignored_targets", targets, 8'h01);
    btn = 8'h01;
    step();
    m_do_hit();
    check("hold_hit_pulse", hit_pulse, 1);
    for (int i = 0; i < 8; i++) begin
      step();
      check("hit_pulse_one_cycle", hit_pulse, 0);
      check("settle_targets", targets, 0);
      check("settle_no_load", pattern_req, 0);
    end
    btn = 8'h00;
    step();
    check("settle_release_load", pattern_req, 1);

    while (m_hits < 25) begin
      pat = 8'($urandom);
      et = (pat == 8'h00) ? 8'h01 : pat;
      wr = 8'($urandom) & ~et;
      play_hit(pat, wr, et, wr, 1'b1);
    end
    check("level_after_25", level, 5);

    play_miss(8'h11, 1'b1);
    play_expiry_hit();

    for (int r = 0; r < 30; r++) begin
      if (m_level() >= 4 && ($urandom % 5) == 0) begin
        play_miss(8'($urandom), 1'b0);
        if (m_lives == 0) begin
          btn = 8'h0F;
          repeat (3) step();
          check("over_score_held", score, m_score);
          check("over_level_held", level, m_level());
          check("over_targets", targets, 0);
          btn = 8'h00;
          start = 1'b1;
          step();
          start = 1'b0;
          m_new_game();
          check("restart_load", pattern_req, 1);
          check("restart_lives", lives_left, 3);
          check("restart_score", score, 0);
        end
      end else begin
        pat = 8'($urandom);
        et = (pat == 8'h00) ? 8'h01 : pat;
        wr = ($urandom % 2) ? (8'($urandom) & ~et) : 8'h00;
        play_hit(pat, wr, et, wr, 1'b1);
      end
    end

    // reset mid-round wins over a simultaneous hit
    pattern_in = 8'h3C;
    wait_req();
    step();
    btn = 8'h40;
    step();
    check("mid_lockout", lockout, 8'h40);
    rst = 1'b1;
    btn = 8'h3C;
    step();
    rst = 1'b0;
    btn = 8'h00;
    check("mid_rst_targets", targets, 0);
    check("mid_rst_lockout", lockout, 0);
    check("mid_rst_score", score, 0);
    check("mid_rst_hit", hit_pulse, 0);
    check("mid_rst_lives", lives_left, 3);
    step();
    check("mid_rst_idle", pattern_req, 0);
    check("mid_rst_no_hit", hit_pulse, 0);

    start = 1'b1;
    step();
    start = 1'b0;
    m_new_game();
    play_hit(8'h33, 8'h00, 8'h33, 8'h00, 1'b0);
    play_hit(8'hC0, 8'h01, 8'hC0, 8'h01, 1'b0);
    repeat (3) play_miss(8'($urandom), 1'b1);
    check("final_game_over", game_over, 1);
    check("final_lives", lives_left, 0);
    btn = 8'hFF;
    tick = 1'b1;
    repeat (5) step();
    check("over_hold_score", score, m_score);
    check("over_no_load", pattern_req, 0);
    btn = 8'h00;
    tick = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    m_new_game();
    check("over_restart_load", pattern_req, 1);
    check("over_restart_score", score, 0);
    check("over_restart_level", level, 0);
    check("over_restart_lives", lives_left, 3);
    check("over_restart_flag", game_over, 0);

    step(); step();
    check("hit_pulse_count", n_hit, tot_hits);
    check("miss_pulse_count", n_miss, tot_miss);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/mole_round_engine.md
MOLE_ROUND_ENGINE -- requirements
Module: mole_round_engine

Interface
REQ-001 SHALL take parameter N_TGT, default 8: number of targets/buttons, 2..16.
REQ-002 SHALL take parameter SCORE_W, default 8: score width.
REQ-003 SHALL take parameter LIVES, default 3: misses allowed before game over, 1..7.
REQ-004 SHALL take parameters ROUND_BASE=5000, ROUND_STEP=1000, ROUND_MIN=1000 (tick counts), LEVEL_HITS=5, all 16-bit.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 Ports: clk in 1 clock; rst in 1 sync active-high reset; start in 1 begin game; tick in 1 timebase enable; btn in N_TGT buttons, already synchronised; pattern_in in N_TGT random pattern; pattern_req out 1 pattern consumed; targets out N_TGT lit targets; lockout out N_TGT locked buttons; score out SCORE_W; lives_left out 3; level out 4; hit_pulse out 1; miss_pulse out 1; game_over out 1.

Function
REQ-007 SHALL implement FSM IDLE, LOAD, ARMED, SETTLE, OVER.
REQ-008 IDLE: targets=0; start=1 moves to LOAD next cycle.
REQ-009 LOAD, one cycle: targets<=pattern_in, or bit 0 only if pattern_in==0; lockout<=0; round counter<=preset; pattern_req=1 for exactly this cycle; next state ARMED.
REQ-010 Round preset SHALL be max(ROUND_BASE-level*ROUND_STEP, ROUND_MIN), saturating with no underflow.
REQ-011 ARMED, hit: every targets bit has its btn bit set and not locked. Response: hit_pulse one cycle, score increments, go to SETTLE.
REQ-012 ARMED, wrong press: btn bits outside targets SHALL OR into lockout; locked bits are ignored by REQ-011 and stay locked until next LOAD.
REQ-013 ARMED, expiry: counter==0 and tick=1. Response: miss_pulse one cycle, lives_left decrements, streak clears, go to SETTLE, or to OVER if lives_left becomes 0.
REQ-014 Counter SHALL decrement only on tick and SHALL hold at 0.
REQ-015 Hit and expiry in the same cycle: hit wins, no miss.
REQ-016 SETTLE SHALL keep targets=0 and wait until btn==0, then go to LOAD. This blocks held-button farming.
REQ-017 level SHALL increment after every LEVEL_HITS hits, saturating at 15.
REQ-018 score SHALL saturate at all-ones.
REQ-019 OVER: targets=0, game_over=1, score and level held. start=1 clears score/level/streak, reloads lives_left=LIVES, goes to LOAD.
REQ-020 start SHALL be ignored outside IDLE and OVER.

Reset
REQ-021 rst SHALL force state IDLE, targets=0, lockout=0, score=0, level=0, lives_left=LIVES, streak=0, all pulses 0, game_over=0, counter=ROUND_BASE. It wins over every other input, including mid-round.

Configuration
REQ-022 Macro MOLE_STREAK_BONUS_EN. When defined: a 3-bit saturating streak counter counts consecutive hits, and a hit with streak>=3 before the increment adds 2 to score (saturating). When undefined: every hit adds 1 and no streak logic exists.

Structure
REQ-023 Package mole_pkg SHALL hold the state enum, default parameter constants and the bonus threshold constant.
REQ-024 SHALL instantiate one sub-module, mole_round_timer (load, tick, count, expired), holding the round counter.

Verification
REQ-025 N_TGT=8: rst, start, pattern_in=8'h05, btn=8'h05 on the 2nd cycle after LOAD, then btn=0 -> hit_pulse, score=1, pattern_req pulses again on the next LOAD.
REQ-026 targets=8'h05, btn=8'h02 then btn=8'h07 -> lockout=8'h02; hit still occurs because bit 1 is outside targets.
REQ-027 tick every cycle, no presses, LIVES=3 -> miss_pulse 3 times at 5001-cycle intervals (+settle/load), game_over=1, lives_left=0.
REQ-028 Button held through hit -> stays in SETTLE with targets=0 until btn==0; pattern_in=0 -> targets=8'h01.
REQ-029 Hit asserted on the expiry cycle -> hit_pulse, no miss_pulse. After 25 hits, level=5 and preset=ROUND_MIN=1000.
REQ-030 With MOLE_STREAK_BONUS_EN, 5 consecutive hits -> score=7 (1+1+1+2+2); a miss then resets the bonus.
